// File: rtl/calc_pkg.sv
// Shared definitions for the calculator result path: 7-segment glyphs,
// display geometry, converter state encodings and small helper functions.
package calc_pkg;

  localparam int NUM_DIGITS = 4;
  localparam int IDX_W      = $clog2(NUM_DIGITS);

  // Glyphs are {g,f,e,d,c,b,a}, active-low (0 lights a segment).
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Double-dabble converter states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } conv_state_e;

  // BCD digit to active-low glyph; anything outside 0..9 shows blank.
  function automatic logic [6:0] seg_decode(input logic [3:0] digit);
    logic [6:0] glyph;
    case (digit)
      4'd0:    glyph = SEG_0;
      4'd1:    glyph = SEG_1;
      4'd2:    glyph = SEG_2;
      4'd3:    glyph = SEG_3;
      4'd4:    glyph = SEG_4;
      4'd5:    glyph = SEG_5;
      4'd6:    glyph = SEG_6;
      4'd7:    glyph = SEG_7;
      4'd8:    glyph = SEG_8;
      4'd9:    glyph = SEG_9;
      default: glyph = SEG_BLANK;
    endcase
    return glyph;
  endfunction

  // Double-dabble correction: a nibble of 5 or more gets 3 added so the
  // following left shift carries correctly into the next decade.
  function automatic logic [3:0] dabble_adj(input logic [3:0] nibble);
    return (nibble >= 4'd5) ? (nibble + 4'd3) : nibble;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential 8-bit binary to 3-digit BCD converter (double dabble, one
// add-and-shift per clock). A start is only honoured in IDLE; done pulses
// for one cycle when bcd takes the new value.
module bin2bcd_seq
  import calc_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  bin,
  output logic        busy,
  output logic        done,
  output logic [11:0] bcd
);

  conv_state_e state_q, state_d;
  logic [19:0] sh_q, sh_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [11:0] bcd_q, bcd_d;
  logic [19:0] sh_adj;

  // Correct each BCD nibble before the shift; binary bits pass through.
  always_comb begin
    sh_adj = {dabble_adj(sh_q[19:16]), dabble_adj(sh_q[15:12]),
              dabble_adj(sh_q[11:8]), sh_q[7:0]};
  end

  // Next-state and registered-output logic for the converter FSM.
  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    bcd_d   = bcd_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          sh_d    = {12'b0, bin};
          cnt_d   = 3'd0;
          busy_d  = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        sh_d  = {sh_adj[18:0], 1'b0};
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == 3'd7) begin
          state_d = DONE;
        end
      end
      DONE: begin
        bcd_d   = sh_q[19:8];
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // Converter state registers; reset abandons any conversion in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      sh_q    <= 20'b0;
      cnt_q   <= 3'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      bcd_q   <= 12'b0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      bcd_q   <= bcd_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign bcd  = bcd_q;

endmodule

// File: rtl/result_display_driver.sv
// Captures the ALU result on each rising edge of alu_done, converts it to
// BCD and drives a multiplexed 4-digit common-anode 7-segment display with
// leading-zero blanking. A capture while a conversion runs is dropped and
// flagged on the sticky overrun output until the next accepted capture.
module result_display_driver
  import calc_pkg::*;
#(
  parameter logic [15:0] REFRESH_CNT = 16'd50000
)
(
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  result_uncoded,
  input  logic        alu_done,
  output logic [11:0] bcd,
  output logic        bcd_valid,
  output logic        busy,
  output logic        overrun,
  output logic [6:0]  seg,
  output logic [3:0]  an
);

  logic             alu_done_q, alu_done_d;
  logic             overrun_q, overrun_d;
  logic [15:0]      refresh_q, refresh_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [6:0]       seg_q, seg_d;
  logic [3:0]       an_q, an_d;
  logic             start;
  logic             conv_busy;
  logic [3:0]       hund, tens, units;

  // A held-high alu_done yields exactly one start on its rising edge.
  assign start = alu_done & ~alu_done_q;

  bin2bcd_seq u_bin2bcd (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .bin   (result_uncoded),
    .busy  (conv_busy),
    .done  (bcd_valid),
    .bcd   (bcd)
  );

  assign busy  = conv_busy;
  assign hund  = bcd[11:8];
  assign tens  = bcd[7:4];
  assign units = bcd[3:0];

  // Edge detect history and the sticky overrun flag.
  always_comb begin
    alu_done_d = alu_done;
    overrun_d  = overrun_q;
    if (start) begin
      overrun_d = conv_busy;
    end
  end

  // Refresh counter and digit index; the index advances on counter wrap.
  always_comb begin
    refresh_d = refresh_q + 16'd1;
    idx_d     = idx_q;
    if (refresh_q >= (REFRESH_CNT - 16'd1)) begin
      refresh_d = 16'd0;
      if (idx_q == IDX_W'(NUM_DIGITS - 1)) begin
        idx_d = '0;
      end else begin
        idx_d = idx_q + IDX_W'(1);
      end
    end
  end

  // Digit content for the current index, with leading-zero blanking.
  always_comb begin
    an_d = ~(4'b0001 << idx_q);
    case (idx_q)
      2'd0:    seg_d = seg_decode(units);
      2'd1:    seg_d = ((hund == 4'd0) && (tens == 4'd0)) ? SEG_BLANK
                                                          : seg_decode(tens);
      2'd2:    seg_d = (hund == 4'd0) ? SEG_BLANK : seg_decode(hund);
      default: seg_d = SEG_BLANK;
    endcase
  end

  // Top-level registers; seg and an update together so they never disagree.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      alu_done_q <= 1'b0;
      overrun_q  <= 1'b0;
      refresh_q  <= 16'd0;
      idx_q      <= '0;
      seg_q      <= SEG_BLANK;
      an_q       <= 4'hF;
    end else begin
      alu_done_q <= alu_done_d;
      overrun_q  <= overrun_d;
      refresh_q  <= refresh_d;
      idx_q      <= idx_d;
      seg_q      <= seg_d;
      an_q       <= an_d;
    end
  end

  assign overrun = overrun_q;
  assign seg     = seg_q;
  assign an      = an_q;

endmodule

// File: tb/tb_result_display_driver.sv
// Directed bench for result_display_driver. Each accepted conversion pushes
// {overrun, bcd} onto exp_q; a monitor pops and compares on every bcd_valid.
module tb_result_display_driver;

  localparam logic [15:0] REFRESH = 16'd4;

  logic        clk;
  logic        rst;
  logic [7:0]  result_uncoded;
  logic        alu_done;
  logic [11:0] bcd;
  logic        bcd_valid;
  logic        busy;
  logic        overrun;
  logic [6:0]  seg;
  logic [3:0]  an;

  logic [12:0] exp_q[$];
  int          n_vec;
  int          n_err;

  result_display_driver #(.REFRESH_CNT(REFRESH)) dut (
    .clk            (clk),
    .rst            (rst),
    .result_uncoded (result_uncoded),
    .alu_done       (alu_done),
    .bcd            (bcd),
    .bcd_valid      (bcd_valid),
    .busy           (busy),
    .overrun        (overrun),
    .seg            (seg),
    .an             (an)
  );

  // Clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference glyph table {g,f,e,d,c,b,a}, active-low.
  function automatic logic [6:0] glyph(input logic [3:0] d);
    case (d)
      4'd0: return 7'h40;
      4'd1: return 7'h79;
      4'd2: return 7'h24;
      4'd3: return 7'h30;
      4'd4: return 7'h19;
      4'd5: return 7'h12;
      4'd6: return 7'h02;
      4'd7: return 7'h78;
      4'd8: return 7'h00;
      4'd9: return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  function automatic logic [6:0] exp_seg(input int idx, input logic [3:0] h,
                                         input logic [3:0] t, input logic [3:0] u);
    case (idx)
      0: return glyph(u);
      1: return (h == 4'd0 && t == 4'd0) ? 7'h7F : glyph(t);
      2: return (h == 4'd0) ? 7'h7F : glyph(h);
      default: return 7'h7F;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec = n_vec + 1;
    if (act !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Driver: present a value and raise alu_done for one cycle; returns just
  // after the capture edge E0.
  task automatic issue(input logic [7:0] v);
    @(negedge clk);
    result_uncoded = v;
    alu_done       = 1'b1;
    @(negedge clk);
    alu_done       = 1'b0;
  endtask

  // Watch the multiplexed display: every lit digit must match the model,
  // the index must step 0->1->2->3->0 and each digit must stay REFRESH clks.
  task automatic check_display(input logic [3:0] h, input logic [3:0] t, input logic [3:0] u);
    logic [3:0] prev_an;
    logic [3:0] seen;
    int         run;
    int         prev_idx;
    int         idx;
    bit         timed;
    repeat (2) @(negedge clk);
    prev_an  = an;
    prev_idx = -1;
    seen     = 4'h0;
    run      = 0;
    timed    = 1'b0;
    for (int c = 0; c < 40; c++) begin
      case (an)
        4'b1110: idx = 0;
        4'b1101: idx = 1;
        4'b1011: idx = 2;
        4'b0111: idx = 3;
        default: idx = -1;
      endcase
      if (idx < 0) begin
        chk("an_onehot", {28'b0, an}, 32'h0);
      end else begin
        seen[idx] = 1'b1;
        chk($sformatf("seg_idx%0d", idx), {25'b0, seg}, {25'b0, exp_seg(idx, h, t, u)});
      end
      if (an != prev_an) begin
        if (timed) chk("digit_dwell", run, REFRESH);
        if (prev_idx >= 0 && idx >= 0) chk("digit_order", idx, (prev_idx + 1) % 4);
        timed = 1'b1;
        run   = 0;
      end
      run      = run + 1;
      prev_an  = an;
      prev_idx = idx;
      @(negedge clk);
    end
    chk("digits_seen", {28'b0, seen}, 32'hF);
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (bcd_valid) begin
      if (exp_q.size() == 0) begin
        n_vec = n_vec + 1;
        n_err = n_err + 1;
        $display("FAIL unexpected_bcd_valid: got bcd=%0h expected no pulse at %0t", bcd, $time);
      end else begin
        logic [12:0] e;
        e = exp_q.pop_front();
        chk("bcd_result", {19'b0, overrun, bcd}, {19'b0, e});
      end
    end
  end

  // Stimulus
  initial begin
    n_vec          = 0;
    n_err          = 0;
    rst            = 1'b0;
    alu_done       = 1'b0;
    result_uncoded = 8'd0;

    // 1: reset values
    repeat (3) @(negedge clk);
    chk("rst_seg", {25'b0, seg}, 32'h7F);
    chk("rst_an", {28'b0, an}, 32'hF);
    chk("rst_bcd", {20'b0, bcd}, 32'h0);
    chk("rst_valid", {31'b0, bcd_valid}, 32'h0);
    chk("rst_busy", {31'b0, busy}, 32'h0);
    chk("rst_overrun", {31'b0, overrun}, 32'h0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // 2: 255, busy E0..E8, result at E9
    exp_q.push_back({1'b0, 12'h255});
    issue(8'd255);
    chk("busy_e0", {31'b0, busy}, 32'h1);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      chk($sformatf("busy_e%0d", k), {31'b0, busy}, 32'h1);
      chk($sformatf("valid_e%0d", k), {31'b0, bcd_valid}, 32'h0);
    end
    @(negedge clk);
    chk("busy_e9", {31'b0, busy}, 32'h0);
    chk("valid_e9", {31'b0, bcd_valid}, 32'h1);
    @(negedge clk);
    chk("valid_e10", {31'b0, bcd_valid}, 32'h0);
    check_display(4'd2, 4'd5, 4'd5);

    // 3: zero and single digit, leading-zero blanking
    exp_q.push_back({1'b0, 12'h000});
    issue(8'd0);
    repeat (10) @(negedge clk);
    check_display(4'd0, 4'd0, 4'd0);
    exp_q.push_back({1'b0, 12'h007});
    issue(8'd7);
    repeat (10) @(negedge clk);
    check_display(4'd0, 4'd0, 4'd7);

    // 4: level held 20 cycles gives one conversion
    exp_q.push_back({1'b0, 12'h100});
    @(negedge clk);
    result_uncoded = 8'd100;
    alu_done       = 1'b1;
    repeat (20) @(negedge clk);
    alu_done = 1'b0;
    repeat (12) @(negedge clk);
    chk("held_bcd", {20'b0, bcd}, 32'h100);

    // 5: rise at E4 is an overrun; next accepted start clears it
    exp_q.push_back({1'b1, 12'h042});
    issue(8'd42);
    chk("ovr_clear_e0", {31'b0, overrun}, 32'h0);
    repeat (3) @(negedge clk);
    result_uncoded = 8'd99;
    alu_done       = 1'b1;
    @(negedge clk);
    chk("ovr_set_e4", {31'b0, overrun}, 32'h1);
    alu_done = 1'b0;
    repeat (10) @(negedge clk);
    chk("ovr_sticky", {31'b0, overrun}, 32'h1);
    exp_q.push_back({1'b0, 12'h099});
    issue(8'd99);
    chk("ovr_cleared", {31'b0, overrun}, 32'h0);
    repeat (12) @(negedge clk);

    // 6: reset mid-conversion
    issue(8'd200);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midrst_bcd", {20'b0, bcd}, 32'h0);
    chk("midrst_busy", {31'b0, busy}, 32'h0);
    chk("midrst_seg", {25'b0, seg}, 32'h7F);
    chk("midrst_an", {28'b0, an}, 32'hF);
    chk("midrst_valid", {31'b0, bcd_valid}, 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (15) @(negedge clk);
    chk("postrst_bcd", {20'b0, bcd}, 32'h0);
    chk("postrst_busy", {31'b0, busy}, 32'h0);

    // 7: 123 on the display, fast refresh
    exp_q.push_back({1'b0, 12'h123});
    issue(8'd123);
    repeat (10) @(negedge clk);
    check_display(4'd1, 4'd2, 4'd3);

    // Drain: every expected result must have arrived
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(negedge clk);
    chk("queue_drained", exp_q.size(), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
